facto_engine: RTL and testbench

//  Parametrised iterative factorial engine; successor to the fixed 64-bit factorial controller.

---
 rtl/facto_engine.sv | 147 ++++++++++++++
 tb/tb_facto_engine.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/facto_engine.sv
// Iterative n! engine: one radix-2 shift-add multiply bit per cycle, one NEXT cycle per factor.
// Optional sticky overflow flag on port ovf is built only when FACTO_OVF_EN is defined.
module facto_engine #(
    parameter int OW = 16,
    parameter int RW = 128
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 op_clear,
    input  logic                 op_start,
    input  logic signed [OW-1:0] oper,
    output logic                 op_busy,
    output logic                 op_done,
    output logic                 op_err,
    output logic [RW-1:0]        result
`ifdef FACTO_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int CW = (OW > 1) ? $clog2(OW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NEXT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    acc_q, acc_d;
    logic [RW-1:0]    result_q, result_d;
    logic [OW-1:0]    k_q, k_d;
    logic [RW+OW-1:0] part_q, part_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            result_q <= '0;
            k_q      <= '0;
            part_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            k_q      <= k_d;
            part_q   <= part_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    // Clear overrides everything; a start is only honoured from IDLE or DONE.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        result_d = result_q;
        k_d      = k_q;
        part_d   = part_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        ovf_d    = ovf_q;

        if (op_clear) begin
            state_d  = IDLE;
            acc_d    = '0;
            result_d = '0;
            k_d      = '0;
            part_d   = '0;
            cnt_d    = '0;
            err_d    = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (op_start) begin
                        ovf_d = 1'b0;
                        if (oper[OW-1]) begin
                            state_d  = DONE;
                            err_d    = 1'b1;
                            result_d = '0;
                        end else if (oper[OW-1:1] == '0) begin
                            state_d  = DONE;
                            err_d    = 1'b0;
                            result_d = RW'(1);
                        end else begin
                            state_d  = MUL;
                            acc_d    = RW'(1);
                            k_d      = $unsigned(oper);
                            part_d   = '0;
                            cnt_d    = '0;
                            err_d    = 1'b0;
                            result_d = '0;
                        end
                    end
                end
                MUL: begin
                    // part is wide enough to hold acc*k without losing any carry.
                    if (k_q[cnt_q])
                        part_d = part_q + ({{OW{1'b0}}, acc_q} << cnt_q);
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(OW - 1)) begin
                        cnt_d   = '0;
                        state_d = NEXT;
                    end
                end
                NEXT: begin
                    acc_d  = part_q[RW-1:0];
                    part_d = '0;
                    cnt_d  = '0;
                    k_d    = k_q - OW'(1);
                    if (part_q[RW+OW-1:RW] != '0)
                        ovf_d = 1'b1;
                    if (k_q == OW'(2)) begin
                        result_d = part_q[RW-1:0];
                        state_d  = DONE;
                    end else begin
                        state_d = MUL;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign op_busy = (state_q == MUL) || (state_q == NEXT);
    assign op_done = (state_q == DONE);
    assign op_err  = err_q;
    assign result  = result_q;

`ifdef FACTO_OVF_EN
    assign ovf = ovf_q;
`else
    logic unusedOvf;
    assign unusedOvf = ovf_q ^ ovf_d;
`endif

endmodule

// File: tb/tb_facto_engine.sv
// Scoreboard bench for facto_engine: expectations queued at start, checked when op_done appears.
// Checks the ovf port as well when FACTO_OVF_EN is defined.
module tb_facto_engine;

    localparam int OW = 16;
    localparam int RW = 128;
    localparam int STEP = OW + 1;

    logic                 clk;
    logic                 reset_n;
    logic                 op_clear;
    logic                 op_start;
    logic signed [OW-1:0] oper;
    logic                 op_busy;
    logic                 op_done;
    logic                 op_err;
    logic [RW-1:0]        result;
`ifdef FACTO_OVF_EN
    logic                 ovf;
`endif

    typedef struct {
        logic [RW-1:0] res;
        bit            err;
        bit            ov;
        int            doneCyc;
        int            n;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   nChecks;
    int   nFails;

    facto_engine #(.OW(OW), .RW(RW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .op_clear (op_clear),
        .op_start (op_start),
        .oper     (oper),
        .op_busy  (op_busy),
        .op_done  (op_done),
        .op_err   (op_err),
        .result   (result)
`ifdef FACTO_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference factorial: ascending product, overflow whenever the exact value leaves RW bits.
    function automatic exp_t model(input int n, input int acceptCyc);
        exp_t e;
        logic [RW+OW-1:0] w;
        e.res = '0;
        e.err = 1'b0;
        e.ov  = 1'b0;
        e.n   = n;
        if (n < 0) begin
            e.err = 1'b1;
            e.doneCyc = acceptCyc;
        end else begin
            e.res = 1;
            for (int i = 2; i <= n; i++) begin
                w = {{OW{1'b0}}, e.res} * (RW+OW)'(i);
                if (w[RW+OW-1:RW] != '0) e.ov = 1'b1;
                e.res = w[RW-1:0];
            end
            e.doneCyc = (n < 2) ? acceptCyc : acceptCyc + (n - 1) * STEP;
        end
        return e;
    endfunction

    task automatic pushStart(input int n);
        @(posedge clk); #1;
        op_start = 1'b1;
        oper     = OW'(n);
        sb.push_back(model(n, cyc + 1));
        @(posedge clk); #1;
        op_start = 1'b0;
    endtask

    // Consumer side of the scoreboard: waits for op_done, pops and compares.
    task automatic collect(input string name);
        exp_t e;
        int guard;
        guard = 0;
        while (!op_done && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        e = sb.pop_front();
        nChecks++;
        if (!op_done) begin
            nFails++;
            $display("[TB] FAIL %s timeout: op_done never rose for n=%0d", name, e.n);
        end else begin
            if (cyc !== e.doneCyc) begin
                nFails++;
                $display("[TB] FAIL %s latency: done at cycle %0d, expected %0d", name, cyc, e.doneCyc);
            end
            nChecks++;
            if (result !== e.res) begin
                nFails++;
                $display("[TB] FAIL %s result: got %0h expected %0h", name, result, e.res);
            end
            nChecks++;
            if (op_err !== e.err) begin
                nFails++;
                $display("[TB] FAIL %s op_err: got %0b expected %0b", name, op_err, e.err);
            end
`ifdef FACTO_OVF_EN
            nChecks++;
            if (ovf !== e.ov) begin
                nFails++;
                $display("[TB] FAIL %s ovf: got %0b expected %0b", name, ovf, e.ov);
            end
`endif
        end
    endtask

    task automatic runOp(input int n, input string name);
        pushStart(n);
        nChecks++;
        if (n >= 2) begin
            if (op_busy !== 1'b1 || op_done !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL %s busy: got busy=%0b done=%0b expected busy=1 done=0", name, op_busy, op_done);
            end
        end else if (op_busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL %s busy: got %0b expected 0", name, op_busy);
        end
        collect(name);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #12;
        nChecks++;
        if ({op_busy, op_done, op_err} !== 3'b000 || result !== '0) begin
            nFails++;
            $display("[TB] FAIL reset: got busy=%0b done=%0b err=%0b result=%0h expected all 0",
                     op_busy, op_done, op_err, result);
        end
`ifdef FACTO_OVF_EN
        nChecks++;
        if (ovf !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_ovf: got %0b expected 0", ovf);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic;
        runOp(5, "fact5");
        runOp(2, "fact2");
        runOp(7, "fact7");
    endtask

    task automatic test_small;
        runOp(0, "fact0");
        runOp(1, "fact1");
    endtask

    task automatic test_negative;
        runOp(-3, "neg3");
        runOp(20, "fact20");
        runOp(-32768, "negmin");
    endtask

    task automatic test_overflow;
        runOp(34, "fact34");
        runOp(35, "fact35");
        runOp(4, "after_ovf");
    endtask

    task automatic checkAborted(input string name);
        nChecks++;
        if ({op_busy, op_done, op_err} !== 3'b000 || result !== '0) begin
            nFails++;
            $display("[TB] FAIL %s: got busy=%0b done=%0b err=%0b result=%0h expected all 0",
                     name, op_busy, op_done, op_err, result);
        end
    endtask

    task automatic test_clear;
        @(posedge clk); #1;
        op_start = 1'b1;
        oper     = OW'(10);
        @(posedge clk); #1;
        op_start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        op_clear = 1'b1;
        @(posedge clk); #1;
        op_clear = 1'b0;
        checkAborted("clear_abort");
        runOp(4, "after_clear");

        @(posedge clk); #1;
        op_start = 1'b1;
        oper     = OW'(10);
        @(posedge clk); #1;
        op_start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkAborted("reset_abort");
        @(negedge clk);
        reset_n = 1'b1;
        runOp(4, "after_reset");

        // Clear and start in the same cycle: the start must be lost.
        @(posedge clk); #1;
        op_clear = 1'b1;
        op_start = 1'b1;
        oper     = OW'(6);
        @(posedge clk); #1;
        op_clear = 1'b0;
        op_start = 1'b0;
        checkAborted("clear_vs_start");
    endtask

    task automatic test_back_to_back;
        pushStart(7);
        repeat (14) @(posedge clk);
        #1;
        op_start = 1'b1;
        oper     = OW'(3);
        repeat (4) @(posedge clk);
        #1;
        op_start = 1'b0;
        oper     = OW'(9);
        collect("busy_ignore");
        runOp(3, "restart_done");
        runOp(6, "restart_again");
    endtask

    initial begin
        nChecks  = 0;
        nFails   = 0;
        op_clear = 1'b0;
        op_start = 1'b0;
        oper     = '0;
        reset_n  = 1'b1;
        test_reset();
        test_basic();
        test_small();
        test_negative();
        test_overflow();
        test_clear();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
